miss_handler: RTL

MISS_HANDLER -- requirements
Module: miss_handler

---
 rtl/cache_pkg.sv | 18 +
 rtl/sat_counter.sv | 21 ++
 rtl/miss_handler.sv | 137 +++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the cache miss handling path.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        FILL = 2'd3
    } state_t;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int MISS_CNT_W  = 16;
    localparam int TMO_CNT_W   = 8;
    // Wide enough for the largest legal TIMEOUT (255).
    localparam int TMO_TIMER_W = 8;

endpackage

// File: rtl/sat_counter.sv
// Statistic counter that increments on inc and sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state is written with <= only, so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/miss_handler.sv
// Single-outstanding cache miss handler: issues one word read to backing
// memory, waits with a timeout, and hands the refill (or an error) back.
module miss_handler
    import cache_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  miss_valid,
    output logic                  miss_ready,
    input  logic [ADDR_W-1:0]     miss_addr,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_W-1:0]     mem_rsp_data,

    output logic                  fill_valid,
    input  logic                  fill_ready,
    output logic [ADDR_W-1:0]     fill_addr,
    output logic [DATA_W-1:0]     fill_data,
    output logic                  fill_err,

    output logic [MISS_CNT_W-1:0] miss_count,
    output logic [TMO_CNT_W-1:0]  timeout_count
);

    localparam logic [TMO_TIMER_W-1:0] TMO_LAST = TMO_TIMER_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0]      WORD_MASK = ~ADDR_W'(3);

    state_t                  state, state_next;
    logic [ADDR_W-1:0]       addr_q;
    logic [DATA_W-1:0]       data_q;
    logic                    err_q;
    logic [TMO_TIMER_W-1:0]  tmo_cnt;

    logic miss_hs;
    logic tmo_hit;
    logic tmo_fire;

    assign miss_hs  = (state == IDLE) && miss_valid;
    assign tmo_hit  = (state == WAIT) && (tmo_cnt == TMO_LAST);
    // A response arriving on the last WAIT cycle beats the timeout.
    assign tmo_fire = tmo_hit && !mem_rsp_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next    = state;
        miss_ready    = 1'b0;
        mem_req_valid = 1'b0;
        fill_valid    = 1'b0;
        case (state)
            IDLE: begin
                miss_ready = 1'b1;
                if (miss_valid) state_next = REQ;
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_next = WAIT;
            end
            WAIT: begin
                if (mem_rsp_valid || tmo_hit) state_next = FILL;
            end
            FILL: begin
                fill_valid = 1'b1;
                if (fill_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (miss_hs) begin
                addr_q <= miss_addr & WORD_MASK;
            end
            if (state == WAIT) begin
                if (mem_rsp_valid) begin
                    data_q <= mem_rsp_data;
                    err_q  <= 1'b0;
                end else if (tmo_hit) begin
                    data_q <= '0;
                    err_q  <= 1'b1;
                end
            end
        end
    end

    // Counts WAIT cycles; held at zero in every other state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state != WAIT) begin
            tmo_cnt <= '0;
        end else if (!tmo_hit) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign mem_addr  = addr_q;
    assign fill_addr = addr_q;
    assign fill_data = data_q;
    assign fill_err  = err_q;

    sat_counter #(.WIDTH(MISS_CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (miss_hs),
        .count (miss_count)
    );

    sat_counter #(.WIDTH(TMO_CNT_W)) u_tmo_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (tmo_fire),
        .count (timeout_count)
    );

endmodule
